execute_mc_stage: RTL and testbench

//  Execute stage plus integral EX/MEM register, directly upstream of memory_stage.

---
 rtl/execute_mc_stage_if.sv | 51 +++++
 rtl/execute_mc_stage.sv | 237 +++++++++++++++++++++++
 tb/tb_execute_mc_stage.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_mc_stage_if.sv
// Execute-stage bus: issue bundle from ID/EX, result bundle to memory_stage.
// Also carries flush in and the stall/busy status back upstream.
interface execute_mc_stage_if #(
  parameter int DATA_WIDTH = 24,
  parameter int DEST_WIDTH = 4
);
  logic                  flush;
  logic                  valid_in;
  logic [3:0]            alu_op;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic [DATA_WIDTH-1:0] store_data;
  logic                  writeback_enable;
  logic                  read_enable;
  logic                  write_enable;
  logic [DEST_WIDTH-1:0] instruction_dest;

  logic                  valid_out;
  logic                  writeback_enable_out;
  logic                  read_enable_out;
  logic                  write_enable_out;
  logic [DEST_WIDTH-1:0] instruction_dest_out;
  logic [DATA_WIDTH-1:0] alu_result_out;
  logic [DATA_WIDTH-1:0] write_data_out;
  logic                  stall_out;
  logic                  busy_out;

  modport master (
    output flush, valid_in, alu_op,
    output operand_a, operand_b, store_data,
    output writeback_enable, read_enable,
    output write_enable, instruction_dest,
    input  valid_out, writeback_enable_out,
    input  read_enable_out, write_enable_out,
    input  instruction_dest_out,
    input  alu_result_out, write_data_out,
    input  stall_out, busy_out
  );

  modport slave (
    input  flush, valid_in, alu_op,
    input  operand_a, operand_b, store_data,
    input  writeback_enable, read_enable,
    input  write_enable, instruction_dest,
    output valid_out, writeback_enable_out,
    output read_enable_out, write_enable_out,
    output instruction_dest_out,
    output alu_result_out, write_data_out,
    output stall_out, busy_out
  );
endinterface

// File: rtl/execute_mc_stage.sv
// Execute stage with integral EX/MEM register and an iterative
// shift-add multiplier that stalls the front end while it runs.
module execute_mc_stage #(
  parameter int DATA_WIDTH = 24,
  parameter int DEST_WIDTH = 4,
  parameter int MUL_BITS   = 4
) (
  input logic               clk,
  input logic               rst,
  execute_mc_stage_if.slave bus
);

  localparam int STEPS = DATA_WIDTH / MUL_BITS;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
  localparam int DW = DATA_WIDTH;
  localparam int TW = DEST_WIDTH;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_PASB = 4'd10;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;

  logic [DW-1:0] r_ma, w_ma_n;
  logic [DW-1:0] r_mb, w_mb_n;
  logic [DW-1:0] r_acc, w_acc_n;

  logic          r_lwb, w_lwb_n;
  logic          r_lrd, w_lrd_n;
  logic          r_lwr, w_lwr_n;
  logic [TW-1:0] r_ldst, w_ldst_n;
  logic [DW-1:0] r_lsd, w_lsd_n;

  logic          r_valid, w_valid_n;
  logic          r_wb, w_wb_n;
  logic          r_rd, w_rd_n;
  logic          r_wr, w_wr_n;
  logic [TW-1:0] r_dst, w_dst_n;
  logic [DW-1:0] r_res, w_res_n;
  logic [DW-1:0] r_wd, w_wd_n;

  logic          w_stall;
  logic [4:0]    w_shamt;
  logic          w_big;
  logic [DW-1:0] w_sra;
  logic          w_lt;
  logic [DW-1:0] w_alu;
  logic [MUL_BITS-1:0] w_chunk;
  logic [DW-1:0] w_partial;
  logic [DW-1:0] w_step;

  // single-cycle ALU for everything except MUL
  always_comb begin
    w_shamt = bus.operand_b[4:0];
    w_big   = ({1'b0, w_shamt} >= 6'(DATA_WIDTH));
    w_sra   = DW'($signed(bus.operand_a) >>> w_shamt);
    w_lt    = ($signed(bus.operand_a) < $signed(bus.operand_b));
    w_alu   = '0;
    case (bus.alu_op)
      OP_ADD:  w_alu = bus.operand_a + bus.operand_b;
      OP_SUB:  w_alu = bus.operand_a - bus.operand_b;
      OP_AND:  w_alu = bus.operand_a & bus.operand_b;
      OP_OR:   w_alu = bus.operand_a | bus.operand_b;
      OP_XOR:  w_alu = bus.operand_a ^ bus.operand_b;
      OP_SLL:  w_alu = w_big ? '0 : (bus.operand_a << w_shamt);
      OP_SRL:  w_alu = w_big ? '0 : (bus.operand_a >> w_shamt);
      OP_SRA:  w_alu = w_big ? {DW{bus.operand_a[DW-1]}} : w_sra;
      OP_SLT:  w_alu = {{(DW-1){1'b0}}, w_lt};
      OP_PASB: w_alu = bus.operand_b;
      default: w_alu = '0;
    endcase
  end

  // one shift-add iteration: consume MUL_BITS of the multiplier
  always_comb begin
    w_chunk   = r_mb[MUL_BITS-1:0];
    w_partial = r_ma * DW'(w_chunk);
    w_step    = r_acc + w_partial;
  end

  // next state, multiplier datapath and EX/MEM contents
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_ma_n    = r_ma;
    w_mb_n    = r_mb;
    w_acc_n   = r_acc;
    w_lwb_n   = r_lwb;
    w_lrd_n   = r_lrd;
    w_lwr_n   = r_lwr;
    w_ldst_n  = r_ldst;
    w_lsd_n   = r_lsd;
    w_valid_n = 1'b0;
    w_wb_n    = 1'b0;
    w_rd_n    = 1'b0;
    w_wr_n    = 1'b0;
    w_dst_n   = '0;
    w_res_n   = '0;
    w_wd_n    = '0;
    w_stall   = 1'b0;
    if (bus.flush) begin
      w_state_n = S_IDLE;
      w_cnt_n   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.valid_in) begin
            if (bus.alu_op == OP_MUL) begin
              w_stall   = 1'b1;
              w_state_n = S_BUSY;
              w_cnt_n   = '0;
              w_acc_n   = '0;
              w_ma_n    = bus.operand_a;
              w_mb_n    = bus.operand_b;
              w_lwb_n   = bus.writeback_enable;
              w_lrd_n   = bus.read_enable;
              w_lwr_n   = bus.write_enable;
              w_ldst_n  = bus.instruction_dest;
              w_lsd_n   = bus.store_data;
            end else begin
              w_valid_n = 1'b1;
              w_res_n   = w_alu;
              w_wb_n    = bus.writeback_enable;
              w_rd_n    = bus.read_enable;
              w_wr_n    = bus.write_enable;
              w_dst_n   = bus.instruction_dest;
              w_wd_n    = bus.store_data;
            end
          end
        end
        S_BUSY: begin
          w_stall = (r_cnt != LAST);
          w_acc_n = w_step;
          w_ma_n  = r_ma << MUL_BITS;
          w_mb_n  = r_mb >> MUL_BITS;
          w_cnt_n = r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            w_state_n = S_IDLE;
            w_cnt_n   = '0;
            w_valid_n = 1'b1;
            w_res_n   = w_step;
            w_wb_n    = r_lwb;
            w_rd_n    = r_lrd;
            w_wr_n    = r_lwr;
            w_dst_n   = r_ldst;
            w_wd_n    = r_lsd;
          end
        end
        default: begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
        end
      endcase
    end
  end

  // FSM state and iteration counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  // multiplier operands, accumulator and latched MUL control
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ma   <= '0;
      r_mb   <= '0;
      r_acc  <= '0;
      r_lwb  <= 1'b0;
      r_lrd  <= 1'b0;
      r_lwr  <= 1'b0;
      r_ldst <= '0;
      r_lsd  <= '0;
    end else begin
      r_ma   <= w_ma_n;
      r_mb   <= w_mb_n;
      r_acc  <= w_acc_n;
      r_lwb  <= w_lwb_n;
      r_lrd  <= w_lrd_n;
      r_lwr  <= w_lwr_n;
      r_ldst <= w_ldst_n;
      r_lsd  <= w_lsd_n;
    end
  end

  // EX/MEM register, bubble unless a result completes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_wb    <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_dst   <= '0;
      r_res   <= '0;
      r_wd    <= '0;
    end else begin
      r_valid <= w_valid_n;
      r_wb    <= w_wb_n;
      r_rd    <= w_rd_n;
      r_wr    <= w_wr_n;
      r_dst   <= w_dst_n;
      r_res   <= w_res_n;
      r_wd    <= w_wd_n;
    end
  end

  assign bus.valid_out            = r_valid;
  assign bus.writeback_enable_out = r_wb;
  assign bus.read_enable_out      = r_rd;
  assign bus.write_enable_out     = r_wr;
  assign bus.instruction_dest_out = r_dst;
  assign bus.alu_result_out       = r_res;
  assign bus.write_data_out       = r_wd;
  assign bus.busy_out             = (r_state == S_BUSY);
  assign bus.stall_out            = w_stall & ~rst;

endmodule

// File: tb/tb_execute_mc_stage.sv
// Bench for execute_mc_stage: directed corner cases plus random
// instruction stream checked against a cycle-count arithmetic model.
module tb_execute_mc_stage;

  localparam longint MASK = 64'hFFFFFF;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  execute_mc_stage_if #(.DATA_WIDTH(24), .DEST_WIDTH(4)) bus ();

  execute_mc_stage #(
    .DATA_WIDTH(24),
    .DEST_WIDTH(4),
    .MUL_BITS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state: occ counts cycles spent on an in-flight MUL
  int          occ;
  logic [23:0] m_res;
  logic [23:0] m_sd;
  logic        m_wb;
  logic        m_rd;
  logic        m_wr;
  logic [3:0]  m_dst;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic logic [23:0] ref_alu(input int op,
                                          input logic [23:0] a,
                                          input logic [23:0] b);
    longint ua, ub, sa, sb, r;
    int sh;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[23] ? ua - 64'd16777216 : ua;
    sb = b[23] ? ub - 64'd16777216 : ub;
    sh = int'(b[4:0]);
    case (op)
      0:  r = ua + ub;
      1:  r = ua - ub + 64'd16777216;
      2:  r = ua & ub;
      3:  r = ua | ub;
      4:  r = ua ^ ub;
      5:  r = (sh >= 24) ? 0 : ua * (64'd1 << sh);
      6:  r = (sh >= 24) ? 0 : ua / (64'd1 << sh);
      7:  r = (sh >= 24) ? ((sa < 0) ? MASK : 0) : (sa >>> sh);
      8:  r = (sa < sb) ? 1 : 0;
      9:  r = ua * ub;
      10: r = ub;
      default: r = 0;
    endcase
    return 24'(r & MASK);
  endfunction

  // one clock: predict, check stall, clock, check EX/MEM
  task automatic tick(input bit fl);
    bit          ev, ewb, erd, ewr, eb, es;
    logic [3:0]  ed;
    logic [23:0] er, ew;
    ev = 0; ewb = 0; erd = 0; ewr = 0; eb = 0; es = 0;
    ed = '0; er = '0; ew = '0;
    bus.flush = fl;
    if (fl) begin
      occ = 0;
    end else if (occ > 0) begin
      es = (occ < 6);
      if (occ == 6) begin
        ev = 1; er = m_res; ew = m_sd;
        ewb = m_wb; erd = m_rd; ewr = m_wr; ed = m_dst;
        occ = 0;
      end else begin
        occ++;
        eb = 1;
      end
    end else if (bus.valid_in) begin
      if (bus.alu_op == 4'd9) begin
        es = 1; eb = 1; occ = 1;
        m_res = ref_alu(9, bus.operand_a, bus.operand_b);
        m_sd  = bus.store_data;
        m_wb  = bus.writeback_enable;
        m_rd  = bus.read_enable;
        m_wr  = bus.write_enable;
        m_dst = bus.instruction_dest;
      end else begin
        ev = 1;
        er = ref_alu(int'(bus.alu_op), bus.operand_a, bus.operand_b);
        ew = bus.store_data;
        ewb = bus.writeback_enable;
        erd = bus.read_enable;
        ewr = bus.write_enable;
        ed  = bus.instruction_dest;
      end
    end
    #2;
    chk("stall", 32'(bus.stall_out), 32'(es));
    @(posedge clk);
    #1;
    chk("valid", 32'(bus.valid_out), 32'(ev));
    chk("result", 32'(bus.alu_result_out), 32'(er));
    chk("wdata", 32'(bus.write_data_out), 32'(ew));
    chk("ctrl",
        32'({bus.writeback_enable_out, bus.read_enable_out,
             bus.write_enable_out, bus.instruction_dest_out}),
        32'({ewb, erd, ewr, ed}));
    chk("busy", 32'(bus.busy_out), 32'(eb));
    bus.flush = 1'b0;
  endtask

  task automatic drive(input int op,
                       input logic [23:0] a,
                       input logic [23:0] b,
                       input logic [23:0] sd,
                       input logic [2:0] en,
                       input logic [3:0] dst);
    bus.valid_in         = 1'b1;
    bus.alu_op           = 4'(op);
    bus.operand_a        = a;
    bus.operand_b        = b;
    bus.store_data       = sd;
    bus.writeback_enable = en[2];
    bus.read_enable      = en[1];
    bus.write_enable     = en[0];
    bus.instruction_dest = dst;
  endtask

  // present one instruction for as long as upstream would hold it
  task automatic issue(input int op,
                       input logic [23:0] a,
                       input logic [23:0] b,
                       input logic [23:0] sd,
                       input logic [2:0] en,
                       input logic [3:0] dst,
                       input int fl_at);
    int n;
    drive(op, a, b, sd, en, dst);
    n = (op == 9) ? 7 : 1;
    for (int i = 0; i < n; i++) begin
      tick(i == fl_at);
      if (i == fl_at) break;
    end
    bus.valid_in = 1'b0;
  endtask

  task automatic bubble();
    bus.valid_in  = 1'b0;
    bus.alu_op    = 4'($urandom_range(0, 15));
    bus.operand_a = 24'($urandom);
    bus.operand_b = 24'($urandom);
    tick(1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_v"}, 32'(bus.valid_out), 32'd0);
    chk({tag, "_res"}, 32'(bus.alu_result_out), 32'd0);
    chk({tag, "_wd"}, 32'(bus.write_data_out), 32'd0);
    chk({tag, "_ctl"},
        32'({bus.writeback_enable_out, bus.read_enable_out,
             bus.write_enable_out, bus.instruction_dest_out}),
        32'd0);
    chk({tag, "_busy"}, 32'(bus.busy_out), 32'd0);
  endtask

  function automatic logic [23:0] rand_opnd();
    logic [23:0] t [6];
    t[0] = 24'h000000; t[1] = 24'hFFFFFF; t[2] = 24'h7FFFFF;
    t[3] = 24'h800000; t[4] = 24'h000001; t[5] = 24'h000018;
    if ($urandom_range(0, 3) == 0)
      return t[$urandom_range(0, 5)];
    return 24'($urandom);
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    occ   = 0;
    m_res = '0; m_sd = '0; m_wb = 0; m_rd = 0; m_wr = 0; m_dst = '0;
    rst   = 1'b1;
    bus.flush = 1'b0;
    drive(9, 24'h000123, 24'h000010, 24'h5A5A5A, 3'b100, 4'd3);
    @(posedge clk);
    #2;
    chk("rst_stall", 32'(bus.stall_out), 32'd0);
    @(posedge clk);
    #1;
    chk_zero("rst");
    rst = 1'b0;
    bus.valid_in = 1'b0;

    issue(0, 24'h7FFFFF, 24'h000001, 24'h0, 3'b100, 4'd1, -1);
    issue(1, 24'h000000, 24'h000001, 24'h0, 3'b100, 4'd2, -1);
    issue(8, 24'hFFFFFF, 24'h000001, 24'h0, 3'b100, 4'd3, -1);
    issue(6, 24'h800000, 24'd30, 24'h0, 3'b100, 4'd4, -1);
    issue(7, 24'h800000, 24'd30, 24'h0, 3'b100, 4'd4, -1);
    issue(9, 24'h000123, 24'h000010, 24'h0, 3'b100, 4'd5, -1);
    issue(9, 24'hFFFFFF, 24'hFFFFFF, 24'h0, 3'b100, 4'd6, -1);
    issue(0, 24'h000002, 24'h000003, 24'h0, 3'b100, 4'd7, -1);
    issue(0, 24'h000100, 24'h000004, 24'hABCDEF, 3'b001, 4'd0, -1);
    issue(9, 24'h00BEEF, 24'h000321, 24'h0, 3'b100, 4'd8, 3);
    bubble();
    issue(9, 24'h000777, 24'h000003, 24'h0, 3'b100, 4'd9, -1);

    drive(9, 24'h123456, 24'h000ABC, 24'h0, 3'b100, 4'd10);
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    rst = 1'b1;
    #2;
    chk("rstmid_stall", 32'(bus.stall_out), 32'd0);
    @(posedge clk);
    #1;
    chk_zero("rstmid");
    occ = 0;
    rst = 1'b0;
    bus.valid_in = 1'b0;
    for (int i = 0; i < 8; i++) bubble();

    for (int n = 0; n < 300; n++) begin
      int op;
      int fl;
      if ($urandom_range(0, 5) == 0) begin
        bubble();
      end else begin
        op = ($urandom_range(0, 4) == 0) ? 9 : int'($urandom_range(0, 15));
        fl = -1;
        if ($urandom_range(0, 14) == 0)
          fl = int'($urandom_range(0, (op == 9) ? 6 : 0));
        issue(op, rand_opnd(), rand_opnd(), 24'($urandom),
              3'($urandom), 4'($urandom), fl);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
